// File: rtl/nor_reduce_seq_ctrl.sv
// nor_reduce_seq_ctrl
// Multi-cycle NOR reduction of an nbits-wide operand. One chunk_nbits-wide
// NOR unit is reused across successive chunks, LSB chunk first. The block
// exits early on the first nonzero chunk.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset    - synchronous, active-high reset
//   in_val   - operand valid
//   in_rdy   - block can accept an operand (IDLE only)
//   in_      - operand, nbits wide
//   out_val  - result valid (DONE only)
//   out_rdy  - consumer accepts the result
//   out      - NOR of all operand bits; 0 whenever out_val is 0
module nor_reduce_seq_ctrl #(
  parameter int nbits       = 16,
  parameter int chunk_nbits = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in_,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out
);

  localparam int NCHUNKS = (nbits / chunk_nbits < 1) ? 1 : nbits / chunk_nbits;
  localparam int CW      = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_acc;
  logic [nbits-1:0]       r_operand;
  logic                   r_in_rdy;
  logic                   r_out_val;
  logic                   r_out;

  logic [chunk_nbits-1:0] w_chunk;
  logic                   w_chunk_nz;
  logic                   w_last;

  // Chunk mux built as a compare-select over all chunk indices so the
  // slice offset never needs a variable-width multiply.
  always_comb begin
    w_chunk = '0;
    for (int unsigned i = 0; i < NCHUNKS; i++) begin
      if (r_cnt == CW'(i)) begin
        w_chunk = r_operand[i*chunk_nbits +: chunk_nbits];
      end
    end
  end

  assign w_chunk_nz = |w_chunk;
  assign w_last     = (r_cnt == CW'(NCHUNKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= 1'b0;
      r_operand <= '0;
      r_in_rdy  <= 1'b1;
      r_out_val <= 1'b0;
      r_out     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_val) begin
            r_operand <= in_;
            r_cnt     <= '0;
            r_acc     <= 1'b1;
            r_in_rdy  <= 1'b0;
            r_state   <= CALC;
          end
        end
        CALC: begin
          if (w_chunk_nz) begin
            r_acc     <= 1'b0;
            r_out     <= 1'b0;
            r_out_val <= 1'b1;
            r_state   <= DONE;
          end else if (w_last) begin
            r_out     <= r_acc;
            r_out_val <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_rdy) begin
            r_out_val <= 1'b0;
            r_out     <= 1'b0;
            r_in_rdy  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_in_rdy  <= 1'b1;
          r_out_val <= 1'b0;
          r_out     <= 1'b0;
        end
      endcase
    end
  end

  assign in_rdy  = r_in_rdy;
  assign out_val = r_out_val;
  assign out     = r_out;

endmodule

// File: doc/nor_reduce_seq_ctrl.md
Name: nor_reduce_seq_ctrl

Overview:
Multi-cycle controller that computes the NOR reduction of a wide nbits operand. It reuses one chunk_nbits-wide NOR reduction unit across successive chunks of the operand. Operands enter and results leave over val/rdy handshakes. The block sits where a full-width single-cycle NOR reduction would cost too much area or timing, and trades latency for width.

Parameters:
nbits, 16, operand width; must be an integer multiple of chunk_nbits
chunk_nbits, 4, width of the shared NOR reduction unit; bits examined per cycle
(derived) nchunks = nbits/chunk_nbits, minimum 1; chunk counter width = max(1, $clog2(nchunks))

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
in_val  input  1  operand valid
in_rdy  output  1  block can accept an operand
in_  input  nbits  operand
out_val  output  1  result valid
out_rdy  input  1  consumer accepts the result
out  output  1  NOR of all nbits of the accepted operand; forced to 0 when out_val=0

Behaviour:
- Interface: one clock (clk) and a synchronous, active-high reset (reset).
- Reset: state=IDLE, chunk counter=0, accumulator=0, operand register=0. Outputs after reset: in_rdy=1, out_val=0, out=0. Asserting reset in any state aborts the operation in flight, discards its result and returns to IDLE on the next edge.
- States:
  - IDLE: in_rdy=1, out_val=0.
  - CALC: in_rdy=0, out_val=0.
  - DONE: in_rdy=0, out_val=1.
- IDLE transition: on an edge where in_val & in_rdy, latch in_ into the operand register, set counter=0 and accumulator=1, and go to CALC. If in_val=0, stay in IDLE.
- CALC, each cycle: chunk c = operand[c*chunk_nbits +: chunk_nbits], where c is the counter value. Chunk 0 holds the LSBs.
  - If chunk c is nonzero: accumulator<=0, go to DONE (early exit).
  - Else if c==nchunks-1: accumulator stays 1, go to DONE.
  - Else: counter<=c+1, stay in CALC.
- DONE: out=accumulator. On an edge where out_rdy=1, go to IDLE. Otherwise hold in DONE with out_val and out stable.
- No overlap: an operand is accepted only in IDLE. After a result transfers, in_rdy rises on the next cycle, so there is never a same-cycle hand-off.
- Latency, with E0 the accepting edge:
  - First nonzero chunk at index i: out_val rises after edge E(i+1).
  - All-zero operand: out_val rises after edge E(nchunks).
  - nchunks==1: out_val always rises after E1.
- in_ and in_val are ignored outside IDLE. out_rdy is ignored outside DONE.
- The operand register does not change between acceptance and result transfer.

Test Plan:
1. Defaults (16,4). Reset for 2 cycles, then accept in_=16'h0000 with out_rdy=1. in_rdy=0 for 5 cycles. out_val=1, out=1 after E4. Back in IDLE (in_rdy=1) after E5.
2. Defaults. in_=16'h0001 -> out_val=1, out=0 after E1. in_=16'h0100 -> after E3, out=0. in_=16'h8000 -> after E4, out=0.
3. Backpressure: in_=16'h0000 with out_rdy=0 for 3 cycles after out_val rises -> out_val=1, out=1 held stable. in_val=1 with a new in_ during this time is not accepted (in_rdy=0). Raise out_rdy -> IDLE next cycle. The new operand is then accepted.
4. Reset mid-CALC: accept 16'h0000, assert reset after E2 -> after the reset edge in_rdy=1, out_val=0, out=0. No result ever appears for that operand.
5. Parameter sweep: nbits=13, chunk_nbits=13 (nchunks=1) with the values 13'h0000 / 13'h1000 / 13'h1111 / 13'h0AAA / 13'h1FFF -> out 1/0/0/0/0, each after E1. nbits=12, chunk_nbits=4 with 12'h000 / 12'h800 -> out 1 after E3, out 0 after E3.
6. Randomized: 20 random 16-bit operands with random out_rdy stalls -> each out equals ~|in_, and each latency matches the first-nonzero-chunk rule.
